// File: rtl/twos_to_signmag_pkg.sv
// Shared definitions for the bit-serial two's-complement to sign-magnitude decoder.
package twos_to_signmag_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage : twos_to_signmag_pkg

// File: rtl/twos_to_signmag_if.sv
// Start/busy/done handshake and result bundle between the controller and the decoder.
interface twos_to_signmag_if
  import twos_to_signmag_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             decoder_start;
  logic [WIDTH-1:0] decoder_input;
  logic             decoder_busy;
  logic             decoder_done;
  logic             decoder_sign;
  logic [WIDTH-1:0] decoder_magnitude;
  logic             decoder_zero;
  logic             decoder_min;

  modport master (
    output decoder_start, decoder_input,
    input  decoder_busy, decoder_done, decoder_sign,
           decoder_magnitude, decoder_zero, decoder_min
  );

  modport slave (
    input  decoder_start, decoder_input,
    output decoder_busy, decoder_done, decoder_sign,
           decoder_magnitude, decoder_zero, decoder_min
  );

endinterface : twos_to_signmag_if

// File: rtl/twos_to_signmag_serial_negate_cell.sv
// One bit of serial negation: copy bits until the first one, then invert.
module serial_negate_cell (
  input  logic i_b,
  input  logic i_sign,
  input  logic i_found_one,
  output logic o_result,
  output logic o_found_one
);

  always_comb begin
    o_result    = i_sign ? (i_b ^ i_found_one) : i_b;
    o_found_one = i_sign ? (i_found_one | i_b) : i_found_one;
  end

endmodule : serial_negate_cell

// File: rtl/twos_to_signmag.sv
// Bit-serial two's-complement to sign-magnitude decoder, one bit per clock.
module twos_to_signmag
  import twos_to_signmag_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic               decoder_clk,
  input logic               decoder_rst,
  twos_to_signmag_if.slave  bus
);

  localparam int unsigned      CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_cap;
  logic             r_found;
  logic [WIDTH-1:0] r_mag;
  logic             r_sign;
  logic             r_zero;
  logic             r_min;

  logic             w_res_bit;
  logic             w_found_next;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  serial_negate_cell u_cell (
    .i_b         (r_shift[0]),
    .i_sign      (r_sign_cap),
    .i_found_one (r_found),
    .o_result    (w_res_bit),
    .o_found_one (w_found_next)
  );

  always_comb begin
    w_last     = (r_cnt == LAST);
    w_acc_next = {w_res_bit, r_acc[WIDTH-1:1]};
  end

  always_ff @(posedge decoder_clk) begin
    if (decoder_rst) r_state <= IDLE;
    else             r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (bus.decoder_start) w_next_state = SHIFT;
      SHIFT:   if (w_last)            w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.decoder_busy      = (r_state == SHIFT);
    bus.decoder_done      = (r_state == DONE);
    bus.decoder_sign      = r_sign;
    bus.decoder_magnitude = r_mag;
    bus.decoder_zero      = r_zero;
    bus.decoder_min       = r_min;
  end

  // zero/min are derived from the final magnitude: only input 0 gives a
  // positive zero, and only the most-negative input gives a negative 2^(W-1).
  always_ff @(posedge decoder_clk) begin
    if (decoder_rst) begin
      r_shift    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_sign_cap <= 1'b0;
      r_found    <= 1'b0;
      r_mag      <= '0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_min      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.decoder_start) begin
            r_shift    <= bus.decoder_input;
            r_sign_cap <= bus.decoder_input[WIDTH-1];
            r_found    <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
          end
        end
        SHIFT: begin
          r_shift <= r_shift >> 1;
          r_acc   <= w_acc_next;
          r_found <= w_found_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_mag  <= w_acc_next;
            r_sign <= r_sign_cap;
            r_zero <= ~r_sign_cap & (w_acc_next == '0);
            r_min  <= r_sign_cap & (w_acc_next == MIN_MAG);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : twos_to_signmag

// File: tb/tb_twos_to_signmag.sv
// Randomised self-checking bench for twos_to_signmag against an arithmetic reference.
module tb_twos_to_signmag;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  twos_to_signmag_if #(.WIDTH(8)) bus ();

  twos_to_signmag #(.WIDTH(8)) dut (
    .decoder_clk (clk),
    .decoder_rst (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: {sign, magnitude, zero, min} from plain signed arithmetic.
  function automatic logic [10:0] ref_out(input logic [7:0] x);
    int v;
    int mag;
    v   = (x >= 8'd128) ? int'(x) - 256 : int'(x);
    mag = (v < 0) ? -v : v;
    return {v < 0, 8'(mag), v == 0, v == -128};
  endfunction

  function automatic logic [10:0] dut_out();
    return {bus.decoder_sign, bus.decoder_magnitude, bus.decoder_zero, bus.decoder_min};
  endfunction

  task automatic convert(input logic [7:0] x, output int busy_n, output int edges,
                         output bit seen);
    @(negedge clk);
    bus.decoder_start = 1'b1;
    bus.decoder_input = x;
    @(negedge clk);
    bus.decoder_start = 1'b0;
    bus.decoder_input = 8'($urandom);
    busy_n = 0;
    edges  = 0;
    seen   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.decoder_done) begin
        seen  = 1'b1;
        edges = i;
        break;
      end
      if (bus.decoder_busy) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.decoder_start = 1'b0;
    bus.decoder_input = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.decoder_busy, bus.decoder_done, dut_out()} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0",
               {bus.decoder_busy, bus.decoder_done, dut_out()});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.decoder_busy, bus.decoder_done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy/done %b expected 00", {bus.decoder_busy, bus.decoder_done});
    end
  endtask

  task automatic test_convert();
    logic [7:0] vals[$];
    int  busy_n, edges;
    bit  seen;
    vals = '{8'h05, 8'hFB, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h01, 8'h81};
    repeat (8) vals.push_back(8'($urandom));
    foreach (vals[k]) begin
      convert(vals[k], busy_n, edges, seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL done_timeout: input %h no done within 20 cycles", vals[k]);
        continue;
      end
      checks++;
      if (edges != 9) begin
        errors++;
        $display("FAIL latency: input %h done after %0d edges expected 9", vals[k], edges);
      end
      checks++;
      if (busy_n != 8 || bus.decoder_busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_len: input %h busy %0d cycles (busy at done %b) expected 8 (0)",
                 vals[k], busy_n, bus.decoder_busy);
      end
      checks++;
      if (dut_out() !== ref_out(vals[k])) begin
        errors++;
        $display("FAIL result: input %h got %h expected %h", vals[k], dut_out(), ref_out(vals[k]));
      end
      @(negedge clk);
      checks++;
      if ({bus.decoder_done, dut_out()} !== {1'b0, ref_out(vals[k])}) begin
        errors++;
        $display("FAIL done_pulse_hold: input %h got %h expected %h", vals[k],
                 {bus.decoder_done, dut_out()}, {1'b0, ref_out(vals[k])});
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones, first;
    logic [10:0] res;
    dones = 0;
    first = 0;
    res   = '0;
    @(negedge clk);
    bus.decoder_start = 1'b1;
    bus.decoder_input = 8'h9C;
    @(negedge clk);
    bus.decoder_start = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) begin
        bus.decoder_start = 1'b1;
        bus.decoder_input = 8'h01;
      end
      if (i == 4) bus.decoder_start = 1'b0;
      if (bus.decoder_done) begin
        dones++;
        if (dones == 1) begin
          first = i;
          res   = dut_out();
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 1 || first != 9) begin
      errors++;
      $display("FAIL ignore_start_done: %0d pulses first at edge %0d expected 1 at 9", dones, first);
    end
    checks++;
    if (res !== ref_out(8'h9C)) begin
      errors++;
      $display("FAIL ignore_start_result: got %h expected %h", res, ref_out(8'h9C));
    end
  endtask

  task automatic test_reset_abort();
    int  dones, busy_n, edges;
    bit  seen;
    dones = 0;
    @(negedge clk);
    bus.decoder_start = 1'b1;
    bus.decoder_input = 8'hF0;
    @(negedge clk);
    bus.decoder_start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 4) rst = 1'b1;
      if (i == 5) begin
        rst = 1'b0;
        checks++;
        if ({bus.decoder_busy, bus.decoder_done, dut_out()} !== 13'd0) begin
          errors++;
          $display("FAIL abort_outputs: got %h expected 0",
                   {bus.decoder_busy, bus.decoder_done, dut_out()});
        end
      end
      if (bus.decoder_done) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d done pulses expected 0", dones);
    end
    convert(8'hF0, busy_n, edges, seen);
    checks++;
    if (!seen || dut_out() !== ref_out(8'hF0)) begin
      errors++;
      $display("FAIL abort_recover: seen %b got %h expected %h", seen, dut_out(), ref_out(8'hF0));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_start_same_edge();
    int dones;
    dones = 0;
    @(negedge clk);
    rst = 1'b1;
    bus.decoder_start = 1'b1;
    bus.decoder_input = 8'h55;
    @(negedge clk);
    rst = 1'b0;
    bus.decoder_start = 1'b0;
    checks++;
    if (bus.decoder_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_busy: busy %b expected 0", bus.decoder_busy);
    end
    for (int i = 0; i < 12; i++) begin
      if (bus.decoder_done || bus.decoder_busy) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_start_dropped: %0d active cycles expected 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int  last_done;
    bit  seen;
    last_done = -1;
    @(negedge clk);
    bus.decoder_start = 1'b1;
    bus.decoder_input = 8'h00;
    for (int k = 0; k < 256; k++) begin
      seen = 1'b0;
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        if (c == 2) bus.decoder_input = 8'($urandom);
        if (bus.decoder_done) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL b2b_timeout: conversion %0d no done", k);
        break;
      end
      checks++;
      if (dut_out() !== ref_out(8'(k))) begin
        errors++;
        $display("FAIL b2b_result: input %h got %h expected %h", 8'(k), dut_out(), ref_out(8'(k)));
      end
      if (last_done >= 0) begin
        checks++;
        if (cyc - last_done != 10) begin
          errors++;
          $display("FAIL b2b_spacing: input %h gap %0d expected 10", 8'(k), cyc - last_done);
        end
      end
      last_done = cyc;
      if (k < 255) bus.decoder_input = 8'(k + 1);
      else         bus.decoder_start = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_convert();
    test_ignore_start();
    test_reset_abort();
    test_reset_start_same_edge();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_twos_to_signmag

// File: doc/twos_to_signmag.md
# twos_to_signmag

Bit-serial decoder that converts a two's-complement ALU result back to sign-magnitude form for the output/display register. It sits after the ALU result register and undoes the negation that the 2's-complement unit applies to operands on the ALU input side. It processes one bit per clock using the copy-until-first-one, then-invert rule. It uses a start/busy/done handshake so that the controller can sequence it like the other multi-cycle units.

## Interface
- WIDTH, 8, data width in bits; must be at least 2.
- decoder_clk  in  1  clock; all state changes on the rising edge.
- decoder_rst  in  1  reset, synchronous, active-high.
- decoder_start  in  1  request a conversion; sampled only in IDLE.
- decoder_input  in  WIDTH  two's-complement value; captured on the accepted start edge.
- decoder_busy  out  1  high while a conversion is in progress.
- decoder_done  out  1  one-cycle pulse; results are valid from this cycle onward.
- decoder_sign  out  1  captured input MSB.
- decoder_magnitude  out  WIDTH  absolute value, unsigned; the most-negative input maps to 2^(WIDTH-1).
- decoder_zero  out  1  input was all zeros.
- decoder_min  out  1  input was the most-negative value (8'h80 at WIDTH=8).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when decoder_start=1 on a clock edge. On that edge:
  - shift register ← decoder_input;
  - sign_r ← decoder_input[WIDTH-1];
  - found_one ← 0;
  - bit counter ← 0.
- SHIFT: each cycle consumes the LSB b of the shift register and shifts right.
  - The result bit enters the accumulator from the MSB side (accumulator shifts right).
  - If sign_r=0, the result bit is b.
  - If sign_r=1, the result bit is b XOR found_one, and found_one ← found_one OR b.
  - The counter increments each cycle. SHIFT → DONE when the counter reaches WIDTH-1 (exactly WIDTH SHIFT cycles).
- On the SHIFT→DONE edge:
  - decoder_magnitude ← final accumulator;
  - decoder_sign ← sign_r;
  - decoder_zero ← (input == 0);
  - decoder_min ← (sign_r AND input[WIDTH-2:0] == 0).
- DONE → IDLE unconditionally after one cycle.
- decoder_start in SHIFT or DONE is ignored; it is neither queued nor does it alter the in-flight result.
- Outputs hold their last values until the next DONE update. decoder_input may change freely after capture.
- Arithmetic:
  - magnitude = sign ? (~x + 1) mod 2^WIDTH : x.
  - The most-negative input yields magnitude 2^(WIDTH-1) with sign=1. This is not an error; decoder_min flags it.
  - Zero yields sign=0, magnitude 0, zero=1.

## Timing
- Reset: state=IDLE, busy=0, done=0, sign=0, magnitude=0, zero=0, min=0, counter=0, found_one=0.
- Start accepted at edge N:
  - busy=1 from N through N+WIDTH;
  - done=1 for exactly the cycle following edge N+WIDTH;
  - busy=0 in the DONE cycle.
- Latency from start edge to done is WIDTH+1 edges. The next start is accepted at edge N+WIDTH+2 at the earliest, so throughput is one conversion per WIDTH+2 cycles.
- Reset during SHIFT or DONE aborts the conversion: no done pulse, and all outputs return to their reset values on that edge.
- decoder_rst and decoder_start high on the same edge: reset wins and the start is dropped.
- A start held high continuously gives back-to-back conversions, each re-sampling decoder_input in IDLE.

## Structure
- Shared package holds:
  - the state encoding constants IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
  - the default WIDTH=8 constant used by the datapath blocks.
- One sub-module, serial_negate_cell:
  - inputs b, sign, found_one;
  - outputs result bit and next found_one;
  - purely combinational.
- The top level owns the FSM, counter, shift register, accumulator and output registers.

## Test plan
- Reset, then start with input 8'h05 → done at start+9 edges; sign=0, magnitude=8'h05, zero=0, min=0.
- Start with input 8'hFB (-5) → sign=1, magnitude=8'h05; busy high for exactly 8 cycles before done.
- Start with 8'h80 → sign=1, magnitude=8'h80, min=1. Start with 8'h00 → sign=0, magnitude=0, zero=1.
- Start with 8'h9C (-100); pulse start again with 8'h01 at cycle 3 of SHIFT → the second start is ignored; result is sign=1, magnitude=8'h64, with only one done pulse.
- Start with 8'hF0; assert decoder_rst at SHIFT cycle 4 → no done pulse, all outputs 0, state IDLE. A new start with 8'hF0 then yields magnitude=8'h10.
- Sweep all 256 inputs back-to-back with start held high → every result matches the reference formula, and done pulses are exactly 10 cycles apart.
